// File: rtl/dcm_rst_seq_if.sv
// Bundle of the lock-supervisor control/status signals shared between the
// bus register block / DCM wrapper (master) and the reset sequencer (slave).
//   LOCKED       DCM lock flag, asynchronous to BUS_CLK
//   SOFT_RST     one-cycle request to force a DCM reset cycle
//   CLR_CNT      one-cycle request to clear LOSS_CNT and TIMEOUT_CNT
//   DCM_RST      reset to the DCM
//   SYS_RST      reset to downstream logic
//   READY        clocks stable, downstream logic running
//   LOSS_CNT     saturating count of lock losses while running
//   TIMEOUT_CNT  saturating count of lock timeouts
interface dcm_rst_seq_if #(
  parameter int unsigned CNT_WIDTH = 8
) ();

  logic                 LOCKED;
  logic                 SOFT_RST;
  logic                 CLR_CNT;
  logic                 DCM_RST;
  logic                 SYS_RST;
  logic                 READY;
  logic [CNT_WIDTH-1:0] LOSS_CNT;
  logic [CNT_WIDTH-1:0] TIMEOUT_CNT;

  modport master (
    output LOCKED,
    output SOFT_RST,
    output CLR_CNT,
    input  DCM_RST,
    input  SYS_RST,
    input  READY,
    input  LOSS_CNT,
    input  TIMEOUT_CNT
  );

  modport slave (
    input  LOCKED,
    input  SOFT_RST,
    input  CLR_CNT,
    output DCM_RST,
    output SYS_RST,
    output READY,
    output LOSS_CNT,
    output TIMEOUT_CNT
  );

endinterface

// File: rtl/dcm_rst_seq.sv
// Reset sequencer / lock supervisor for the DCM clock generator.
// Synchronises LOCKED, holds SYS_RST until lock has been stable for STABLE_CYCLES,
// re-asserts SYS_RST on lock loss and pulses DCM_RST when lock does not arrive
// within TIMEOUT_CYCLES. Keeps saturating loss/timeout counters.
// Ports:
//   BUS_CLK  single clock
//   BUS_RST  asynchronous active-high reset
//   bus_io   dcm_rst_seq_if slave: LOCKED/SOFT_RST/CLR_CNT in,
//            DCM_RST/SYS_RST/READY/LOSS_CNT/TIMEOUT_CNT out (all registered)
module dcm_rst_seq #(
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 65536,
  parameter int unsigned DCM_RST_CYCLES = 8,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic           BUS_CLK,
  input  logic           BUS_RST,
  dcm_rst_seq_if.slave   bus_io
);

  localparam int unsigned MaxAB =
    (STABLE_CYCLES > TIMEOUT_CYCLES) ? STABLE_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned MaxCycles = (MaxAB > DCM_RST_CYCLES) ? MaxAB : DCM_RST_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles);

  typedef logic [CntW-1:0]      cnt_t;
  typedef logic [CNT_WIDTH-1:0] evt_t;

  localparam cnt_t StableLast  = cnt_t'(STABLE_CYCLES - 1);
  localparam cnt_t TimeoutLast = cnt_t'(TIMEOUT_CYCLES - 1);
  localparam cnt_t DcmRstLast  = cnt_t'(DCM_RST_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWaitLock,
    StStable,
    StRun,
    StDcmReset
  } state_e;

  state_e state_q, state_d;
  cnt_t   cnt_q, cnt_d;
  logic   sync1_q, lock_s_q;
  logic   dcm_rst_q, dcm_rst_d;
  logic   sys_rst_q, sys_rst_d;
  logic   ready_q, ready_d;
  evt_t   loss_cnt_q, loss_cnt_d;
  evt_t   timeout_cnt_q, timeout_cnt_d;
  logic   loss_inc, timeout_inc;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    loss_inc    = 1'b0;
    timeout_inc = 1'b0;

    // SOFT_RST wins from any state; re-entry also restarts the DCM_RST pulse.
    if (bus_io.SOFT_RST) begin
      state_d = StDcmReset;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end
        StWaitLock: begin
          if (lock_s_q) begin
            state_d = StStable;
            cnt_d   = '0;
          end else if (cnt_q == TimeoutLast) begin
            state_d     = StDcmReset;
            cnt_d       = '0;
            timeout_inc = 1'b1;
          end else begin
            cnt_d = cnt_q + cnt_t'(1);
          end
        end
        StStable: begin
          if (!lock_s_q) begin
            state_d = StWaitLock;
            cnt_d   = '0;
          end else if (cnt_q == StableLast) begin
            state_d = StRun;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + cnt_t'(1);
          end
        end
        StRun: begin
          if (!lock_s_q) begin
            state_d  = StWaitLock;
            cnt_d    = '0;
            loss_inc = 1'b1;
          end
        end
        StDcmReset: begin
          if (cnt_q == DcmRstLast) begin
            state_d = StWaitLock;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + cnt_t'(1);
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs decode the next state so they change on the same edge as the state.
  always_comb begin
    dcm_rst_d = (state_d == StDcmReset);
    sys_rst_d = (state_d != StRun);
    ready_d   = (state_d == StRun);
  end

  // A clear wins over a coincident increment.
  always_comb begin
    loss_cnt_d    = loss_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    if (bus_io.CLR_CNT) begin
      loss_cnt_d    = '0;
      timeout_cnt_d = '0;
    end else begin
      if (loss_inc && (loss_cnt_q != '1)) begin
        loss_cnt_d = loss_cnt_q + evt_t'(1);
      end
      if (timeout_inc && (timeout_cnt_q != '1)) begin
        timeout_cnt_d = timeout_cnt_q + evt_t'(1);
      end
    end
  end

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      sync1_q       <= 1'b0;
      lock_s_q      <= 1'b0;
      dcm_rst_q     <= 1'b0;
      sys_rst_q     <= 1'b1;
      ready_q       <= 1'b0;
      loss_cnt_q    <= '0;
      timeout_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sync1_q       <= bus_io.LOCKED;
      lock_s_q      <= sync1_q;
      dcm_rst_q     <= dcm_rst_d;
      sys_rst_q     <= sys_rst_d;
      ready_q       <= ready_d;
      loss_cnt_q    <= loss_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
    end
  end

  assign bus_io.DCM_RST     = dcm_rst_q;
  assign bus_io.SYS_RST     = sys_rst_q;
  assign bus_io.READY       = ready_q;
  assign bus_io.LOSS_CNT    = loss_cnt_q;
  assign bus_io.TIMEOUT_CNT = timeout_cnt_q;

endmodule

// File: tb/tb_dcm_rst_seq.sv
// Self-checking bench for dcm_rst_seq with STABLE=16, TIMEOUT=64, DCM_RST=4, CNT_WIDTH=8.
// A phase/duration model advances once per rising edge; a negedge process compares it
// against the DUT, and directed scenarios add hand-computed literal expectations.
module tb_dcm_rst_seq;

  localparam int ST = 16;
  localparam int TO = 64;
  localparam int DR = 4;
  localparam int CW = 8;
  localparam int SAT = (1 << CW) - 1;

  localparam int PhIdle   = 0;
  localparam int PhWait   = 1;
  localparam int PhStable = 2;
  localparam int PhRun    = 3;
  localparam int PhDcm    = 4;

  logic clk;
  logic rst;

  dcm_rst_seq_if #(.CNT_WIDTH(CW)) bus ();

  dcm_rst_seq #(
    .STABLE_CYCLES (ST),
    .TIMEOUT_CYCLES(TO),
    .DCM_RST_CYCLES(DR),
    .CNT_WIDTH     (CW)
  ) dut (
    .BUS_CLK(clk),
    .BUS_RST(rst),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  // Model state: phase, cycles spent in phase, lock history (2-deep), counters.
  int m_phase, m_cnt, m_h1, m_h2, m_loss, m_to;
  int m_dcm, m_sys, m_ready;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  task automatic model_outputs();
    m_dcm   = (m_phase == PhDcm) ? 1 : 0;
    m_ready = (m_phase == PhRun) ? 1 : 0;
    m_sys   = 1 - m_ready;
  endtask

  task automatic model_reset();
    m_phase = PhIdle;
    m_cnt   = 0;
    m_h1    = 0;
    m_h2    = 0;
    m_loss  = 0;
    m_to    = 0;
    model_outputs();
  endtask

  task automatic model_edge();
    int  ls;
    int  nph;
    bit  linc;
    bit  tinc;
    ls   = m_h2;
    m_h2 = m_h1;
    m_h1 = int'(bus.LOCKED);
    nph  = m_phase;
    linc = 1'b0;
    tinc = 1'b0;
    if (bus.SOFT_RST) begin
      nph = PhDcm;
    end else begin
      case (m_phase)
        PhIdle:   nph = PhWait;
        PhWait:   if (ls == 1) nph = PhStable;
                  else if (m_cnt == TO - 1) begin nph = PhDcm; tinc = 1'b1; end
        PhStable: if (ls == 0) nph = PhWait;
                  else if (m_cnt == ST - 1) nph = PhRun;
        PhRun:    if (ls == 0) begin nph = PhWait; linc = 1'b1; end
        PhDcm:    if (m_cnt == DR - 1) nph = PhWait;
        default:  nph = PhIdle;
      endcase
    end
    // Any entry (including SOFT_RST re-entry of the DCM reset) restarts the duration.
    if (nph != m_phase || bus.SOFT_RST) m_cnt = 0;
    else m_cnt = m_cnt + 1;
    m_phase = nph;
    if (bus.CLR_CNT) begin
      m_loss = 0;
      m_to   = 0;
    end else begin
      if (linc) m_loss = sat_inc(m_loss);
      if (tinc) m_to = sat_inc(m_to);
    end
    model_outputs();
  endtask

  // One rising edge; the model sees the same inputs the DUT sampled.
  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("DCM_RST", int'(bus.DCM_RST), m_dcm);
      check("SYS_RST", int'(bus.SYS_RST), m_sys);
      check("READY", int'(bus.READY), m_ready);
      check("LOSS_CNT", int'(bus.LOSS_CNT), m_loss);
      check("TIMEOUT_CNT", int'(bus.TIMEOUT_CNT), m_to);
    end
  end

  task automatic wait_ready(input string name, input int budget, output int edges);
    edges = 0;
    while (!bus.READY && edges < budget) begin
      step();
      edges++;
    end
    check(name, int'(bus.READY), 1);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    model_reset();
    repeat (2) step();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int edges;
    int hi;
    int lo;
    int first;
    rst          = 1'b1;
    bus.LOCKED   = 1'b1;
    bus.SOFT_RST = 1'b0;
    bus.CLR_CNT  = 1'b0;
    model_reset();
    chk_en = 1'b1;
    repeat (2) step();
    check("rst_sys_rst", int'(bus.SYS_RST), 1);
    check("rst_dcm_rst", int'(bus.DCM_RST), 0);
    check("rst_ready", int'(bus.READY), 0);
    @(negedge clk);
    rst = 1'b0;

    // T1: IDLE until e1, WAIT sees synced lock at e3, 16 STABLE cycles -> RUN at e19.
    wait_ready("t1_reach_run", 40, edges);
    check("t1_edges_to_run", edges, 19);
    check("t1_sys_rst_low", int'(bus.SYS_RST), 0);

    // T2: one-cycle lock drop sampled at edge t; RUN sees it at t+2.
    bus.LOCKED = 1'b0;
    step();
    bus.LOCKED = 1'b1;
    step();
    check("t2_still_run_t1", int'(bus.READY), 1);
    step();
    check("t2_sys_rst_t2", int'(bus.SYS_RST), 1);
    check("t2_loss_cnt", int'(bus.LOSS_CNT), 1);
    wait_ready("t2_rerun", 40, edges);
    check("t2_edges_to_rerun", edges, 17);

    // T6a: SOFT_RST in RUN -> 4-cycle DCM_RST, no loss counted.
    bus.SOFT_RST = 1'b1;
    step();
    bus.SOFT_RST = 1'b0;
    hi = int'(bus.DCM_RST);
    check("t6_sys_rst", int'(bus.SYS_RST), 1);
    repeat (6) begin
      step();
      hi += int'(bus.DCM_RST);
    end
    check("t6_dcm_width", hi, 4);
    check("t6_loss_unchanged", int'(bus.LOSS_CNT), 1);
    wait_ready("t6_rerun", 40, edges);

    // T6b: second SOFT_RST three cycles into the pulse restarts it: 3 + 4 cycles high.
    bus.SOFT_RST = 1'b1;
    step();
    bus.SOFT_RST = 1'b0;
    hi = int'(bus.DCM_RST);
    repeat (2) begin
      step();
      hi += int'(bus.DCM_RST);
    end
    bus.SOFT_RST = 1'b1;
    step();
    bus.SOFT_RST = 1'b0;
    hi += int'(bus.DCM_RST);
    repeat (6) begin
      step();
      hi += int'(bus.DCM_RST);
    end
    check("t6_restart_width", hi, 7);
    wait_ready("t6_rerun2", 40, edges);

    // T6c: BUS_RST mid-DCM_RESET takes effect without waiting for an edge.
    bus.SOFT_RST = 1'b1;
    step();
    bus.SOFT_RST = 1'b0;
    step();
    check("t6_in_dcm_reset", int'(bus.DCM_RST), 1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("t6_async_dcm_rst", int'(bus.DCM_RST), 0);
    check("t6_async_sys_rst", int'(bus.SYS_RST), 1);
    check("t6_async_ready", int'(bus.READY), 0);
    check("t6_async_loss", int'(bus.LOSS_CNT), 0);
    check("t6_async_timeout", int'(bus.TIMEOUT_CNT), 0);
    step();
    @(negedge clk);
    rst = 1'b0;

    // T3: no lock ever; first timeout at e65, pulse after e65..e68, period 68.
    bus.LOCKED = 1'b0;
    do_reset();
    hi    = 0;
    lo    = 0;
    first = 0;
    for (int i = 1; i <= 205; i++) begin
      step();
      hi += int'(bus.DCM_RST);
      if (!bus.SYS_RST) lo++;
      if (bus.DCM_RST && first == 0) first = i;
    end
    check("t3_first_pulse_edge", first, 65);
    check("t3_dcm_high_cycles", hi, 12);
    check("t3_timeout_cnt", int'(bus.TIMEOUT_CNT), 3);
    check("t3_sys_rst_never_low", lo, 0);

    // T4: 10-high/10-low lock never qualifies 16 stable cycles.
    do_reset();
    hi = 0;
    for (int i = 0; i < 200; i++) begin
      bus.LOCKED = ((i / 10) % 2 == 0) ? 1'b1 : 1'b0;
      step();
      hi += int'(bus.READY);
    end
    check("t4_ready_never", hi, 0);
    check("t4_loss_cnt", int'(bus.LOSS_CNT), 0);

    // T5: 300 losses saturate at 255; CLR_CNT coincident with a loss gives 0.
    bus.LOCKED = 1'b1;
    do_reset();
    wait_ready("t5_first_run", 40, edges);
    for (int k = 0; k < 300; k++) begin
      bus.LOCKED = 1'b0;
      step();
      bus.LOCKED = 1'b1;
      repeat (2) step();
      wait_ready("t5_loss_rerun", 30, edges);
    end
    check("t5_loss_saturated", int'(bus.LOSS_CNT), 255);
    bus.LOCKED = 1'b0;
    step();
    bus.LOCKED = 1'b1;
    step();
    bus.CLR_CNT = 1'b1;
    step();
    bus.CLR_CNT = 1'b0;
    check("t5_clr_with_loss", int'(bus.LOSS_CNT), 0);
    check("t5_loss_happened", int'(bus.SYS_RST), 1);
    wait_ready("t5_final_run", 40, edges);

    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
